cla_serial_addsub: RTL

//  Multi-cycle, parametrised add/subtract unit. Operands are WIDTH bits wide.

---
 rtl/cla_serial_addsub.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cla_serial_addsub.sv
// Serial add/subtract: one GROUP-bit carry-lookahead slice per clock, LSB first.
// Optional signed-overflow output enabled by defining CLA_SERIAL_OVF_EN.
module cla_serial_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
`ifdef CLA_SERIAL_OVF_EN
  output logic             o_cout,
  output logic             o_ovf
`else
  output logic             o_cout
`endif
);

  localparam int unsigned N     = WIDTH / GROUP;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state, w_state_next;
  logic [WIDTH-1:0]   r_a, r_b, r_sum;
  logic               r_carry, r_cout;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_accept, w_last, w_term;
  logic [GROUP-1:0]   w_a_sl, w_b_sl, w_g, w_p, w_s;
  logic [GROUP:0]     w_c;

  assign w_accept = i_start && (r_state != StRun);
  assign w_last   = (r_cnt == CNT_W'(N - 1));

  assign w_a_sl = r_a[r_cnt*GROUP +: GROUP];
  assign w_b_sl = r_b[r_cnt*GROUP +: GROUP];
  assign w_g    = w_a_sl & w_b_sl;
  assign w_p    = w_a_sl ^ w_b_sl;
  assign w_s    = w_p ^ w_c[GROUP-1:0];

  // Each carry is a flat sum-of-products of g/p and the slice carry-in (no ripple chain).
  always_comb begin
    w_c    = '0;
    w_term = 1'b0;
    for (int i = 0; i <= int'(GROUP); i++) begin
      w_c[i] = r_carry;
      for (int j = 0; j < i; j++) w_c[i] = w_c[i] & w_p[j];
      for (int j = 0; j < i; j++) begin
        w_term = w_g[j];
        for (int k = j + 1; k < i; k++) w_term = w_term & w_p[k];
        w_c[i] = w_c[i] | w_term;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = i_start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

`ifdef CLA_SERIAL_OVF_EN
  logic r_ovf;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
`ifdef CLA_SERIAL_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1, so invert b once here and force the carry-in.
      r_a     <= i_a;
      r_b     <= i_sub ? ~i_b : i_b;
      r_carry <= i_sub | i_cin;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (r_state == StRun) begin
      r_sum[r_cnt*GROUP +: GROUP] <= w_s;
      r_carry <= w_c[GROUP];
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_cout <= w_c[GROUP];
`ifdef CLA_SERIAL_OVF_EN
        r_ovf  <= w_c[GROUP-1] ^ w_c[GROUP];
`endif
      end
    end
  end

  assign o_busy = (r_state == StRun);
  assign o_done = (r_state == StDone);
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
`ifdef CLA_SERIAL_OVF_EN
  assign o_ovf  = r_ovf;
`endif

endmodule
